// File: rtl/timer_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : timer_pkg
//  Purpose  : Shared types and constants for the 60-second timer.
//             Holds the run-control state encoding and the BCD digit limits
//             used by the seconds counter.
//  Revision : 1.0  initial release
// ============================================================================
package timer_pkg;

  // Run-control states of the seconds counter.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } state_t;

  // Highest legal value of each BCD digit.
  localparam logic [3:0] ONES_MAX = 4'd9;
  localparam logic [3:0] TENS_MAX = 4'd5;

endpackage : timer_pkg
`default_nettype wire

// File: rtl/button_sync_edge.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : button_sync_edge
//  Purpose  : Brings one raw active-low pushbutton into the clk domain and
//             reports each press as a single-cycle pulse.
//  Ports    : clk     - board clock
//             reset_n - asynchronous active-low reset
//             btn_n   - raw button, low while pressed, asynchronous to clk
//             press   - one-cycle high pulse per 1->0 transition of the
//                       synchronized button
//  Revision : 1.0  initial release
// ============================================================================
module button_sync_edge (
  input  logic clk,
  input  logic reset_n,
  input  logic btn_n,
  output logic press
);

  logic r_sync1;
  logic r_sync2;
  logic r_prev;

  // All three flops reset to 1 so a released button never looks like a press
  // coming out of reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
      r_prev  <= 1'b1;
    end else begin
      r_sync1 <= btn_n;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
    end
  end

  // Falling edge of the synchronized level; a held button yields one pulse.
  assign press = r_prev & ~r_sync2;

endmodule : button_sync_edge
`default_nettype wire

// File: rtl/seconds_counter_60.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : seconds_counter_60
//  Purpose  : Divides the board clock to a one-second tick and runs a BCD
//             seconds count 00..59 under start/stop and clear buttons.
//  Ports    : clk          - board clock, rising-edge active
//             reset_n      - asynchronous active-low reset
//             start_stop_n - raw active-low button, each press toggles
//                            run/pause
//             clear_n      - raw active-low button, zeroes count and stops
//             ones         - BCD ones digit, 0..9
//             tens         - BCD tens digit, 0..5
//             running      - high while in RUN
//             wrap         - one-cycle pulse on the 59 -> 00 transition
//  Revision : 1.0  initial release
// ============================================================================
module seconds_counter_60
  import timer_pkg::*;
#(
  parameter int TICKS_PER_SEC = 50_000_000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start_stop_n,
  input  logic       clear_n,
  output logic [3:0] ones,
  output logic [3:0] tens,
  output logic       running,
  output logic       wrap
);

  localparam int                 c_PRE_W    = (TICKS_PER_SEC > 2) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [c_PRE_W-1:0] c_PRE_LAST = c_PRE_W'(TICKS_PER_SEC - 1);

  logic               w_start;
  logic               w_clr;
  logic               w_run;
  logic               w_tick;
  state_t             r_state;
  state_t             w_state_nxt;
  logic [c_PRE_W-1:0] r_presc;
  logic [3:0]         r_ones;
  logic [3:0]         r_tens;
  logic               r_running;
  logic               r_wrap;

  // --------------------------------------------------------------------------
  // Button conditioning
  // --------------------------------------------------------------------------
  button_sync_edge u_start_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .btn_n   (start_stop_n),
    .press   (w_start)
  );

  button_sync_edge u_clear_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .btn_n   (clear_n),
    .press   (w_clr)
  );

  // --------------------------------------------------------------------------
  // Run-control FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= IDLE;
      r_running <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_running <= (w_state_nxt == RUN);
    end
  end

  // Clear has priority over a simultaneous start press.
  always_comb begin
    w_state_nxt = r_state;
    if (w_clr) begin
      w_state_nxt = IDLE;
    end else if (w_start) begin
      case (r_state)
        IDLE:    w_state_nxt = RUN;
        RUN:     w_state_nxt = PAUSE;
        PAUSE:   w_state_nxt = RUN;
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Prescaler and BCD count
  // --------------------------------------------------------------------------
  // The count advances on every cycle spent in RUN, including the cycle in
  // which a pause press is acted on, so a second always takes exactly
  // TICKS_PER_SEC cycles of RUN regardless of where it was interrupted.
  assign w_run  = (r_state == RUN);
  assign w_tick = w_run && (r_presc == c_PRE_LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_presc <= '0;
      r_ones  <= 4'd0;
      r_tens  <= 4'd0;
      r_wrap  <= 1'b0;
    end else begin
      r_wrap <= 1'b0;
      if (w_clr) begin
        r_presc <= '0;
        r_ones  <= 4'd0;
        r_tens  <= 4'd0;
      end else if (w_run) begin
        if (w_tick) begin
          r_presc <= '0;
          if (r_ones < ONES_MAX) begin
            r_ones <= r_ones + 4'd1;
          end else begin
            r_ones <= 4'd0;
            if (r_tens == TENS_MAX) begin
              r_tens <= 4'd0;
              r_wrap <= 1'b1;
            end else begin
              r_tens <= r_tens + 4'd1;
            end
          end
        end else begin
          r_presc <= r_presc + 1'b1;
        end
      end
    end
  end

  assign ones    = r_ones;
  assign tens    = r_tens;
  assign running = r_running;
  assign wrap    = r_wrap;

endmodule : seconds_counter_60
`default_nettype wire

// File: tb/tb_seconds_counter_60.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_seconds_counter_60
//  Purpose  : Self-checking bench for seconds_counter_60 with TICKS_PER_SEC=4.
//             A behavioural model tracks elapsed seconds as a plain integer
//             and the button timing as a sample history; it is compared with
//             the DUT every cycle, alongside hand-computed expectations.
//  Revision : 1.0  initial release
// ============================================================================
module tb_seconds_counter_60;

  localparam int T = 4;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       start_stop_n;
  logic       clear_n;
  logic [3:0] ones;
  logic [3:0] tens;
  logic       running;
  logic       wrap;

  int checks = 0;
  int errors = 0;
  bit chk_on = 1'b0;

  seconds_counter_60 #(.TICKS_PER_SEC(T)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .start_stop_n (start_stop_n),
    .clear_n      (clear_n),
    .ones         (ones),
    .tens         (tens),
    .running      (running),
    .wrap         (wrap)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout actual=running required=finished");
    $fatal(1);
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // --------------------------------------------------------------------------
  // Behavioural model: seconds as an integer, mode 0=idle 1=run 2=pause.
  // A press sampled low at edge k (after a high sample) acts at edge k+2.
  // --------------------------------------------------------------------------
  int m_secs, m_cyc, m_mode;
  bit m_wrap;
  bit s_h0, s_h1, s_h2, c_h0, c_h1, c_h2;
  bit sev, cev;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_secs = 0; m_cyc = 0; m_mode = 0; m_wrap = 0;
      s_h0 = 1; s_h1 = 1; s_h2 = 1;
      c_h0 = 1; c_h1 = 1; c_h2 = 1;
    end else begin
      sev = !s_h1 && s_h2;
      cev = !c_h1 && c_h2;
      s_h2 = s_h1; s_h1 = s_h0; s_h0 = start_stop_n;
      c_h2 = c_h1; c_h1 = c_h0; c_h0 = clear_n;
      m_wrap = 0;
      if (cev) begin
        m_mode = 0; m_secs = 0; m_cyc = 0;
      end else begin
        if (m_mode == 1) begin
          m_cyc++;
          if (m_cyc == T) begin
            m_cyc = 0;
            if (m_secs == 59) begin m_secs = 0; m_wrap = 1; end
            else m_secs++;
          end
        end
        if (sev) m_mode = (m_mode == 1) ? 2 : 1;
      end
    end
  end

  always @(negedge clk) begin
    if (reset_n && chk_on) begin
      chk("cyc_ones",    int'(ones),    m_secs % 10);
      chk("cyc_tens",    int'(tens),    m_secs / 10);
      chk("cyc_running", int'(running), (m_mode == 1) ? 1 : 0);
      chk("cyc_wrap",    int'(wrap),    int'(m_wrap));
    end
  end

  // Drive a button low for 'hold' cycles starting at the current negedge.
  task automatic press_btn(input bit which_clr, input int hold);
    if (which_clr) clear_n = 1'b0; else start_stop_n = 1'b0;
    repeat (hold) @(negedge clk);
    if (which_clr) clear_n = 1'b1; else start_stop_n = 1'b1;
  endtask

  int n;
  int r;

  initial begin
    reset_n = 1'b0; start_stop_n = 1'b1; clear_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_ones", int'(ones), 0);
    chk("rst_tens", int'(tens), 0);
    chk("rst_running", int'(running), 0);
    chk("rst_wrap", int'(wrap), 0);
    reset_n = 1'b1;
    chk_on = 1'b1;
    repeat (5) @(negedge clk);
    chk("idle_running", int'(running), 0);

    // Start and count: RUN from edge s, first increment at s+T, 10 at s+40.
    press_btn(1'b0, 1);
    n = 0;
    while (!running && n < 10) begin @(negedge clk); n++; end
    chk("start_latency", n, 2);
    n = 0;
    while (ones == 4'd0 && n < 20) begin @(negedge clk); n++; end
    chk("first_inc_cycles", n, T);
    chk("first_inc_ones", int'(ones), 1);
    repeat (36) @(negedge clk);
    chk("carry_tens", int'(tens), 1);
    chk("carry_ones", int'(ones), 0);

    // Wrap at s+240, single-cycle pulse, counting continues.
    n = 0;
    while (!wrap && n < 300) begin @(negedge clk); n++; end
    chk("wrap_cycles", n, 200);
    chk("wrap_ones", int'(ones), 0);
    chk("wrap_tens", int'(tens), 0);
    @(negedge clk);
    chk("wrap_pulse_end", int'(wrap), 0);
    repeat (3) @(negedge clk);
    chk("after_wrap_ones", int'(ones), 1);

    // Pause two RUN cycles into a second, then resume.
    repeat (3) @(negedge clk);
    press_btn(1'b0, 1);
    n = 0;
    while (running && n < 10) begin @(negedge clk); n++; end
    chk("pause_latency", n, 2);
    repeat (20) @(negedge clk);
    chk("paused_ones", int'(ones), 2);
    chk("paused_tens", int'(tens), 0);
    press_btn(1'b0, 1);
    n = 0;
    while (!running && n < 10) begin @(negedge clk); n++; end
    chk("resume_latency", n, 2);
    n = 0;
    while (ones == 4'd2 && n < 20) begin @(negedge clk); n++; end
    chk("resume_inc_cycles", n, 2);
    chk("resume_ones", int'(ones), 3);

    // Clear and start together at 23; held start gives no further toggle.
    n = 0;
    while (!(tens == 4'd2 && ones == 4'd3) && n < 200) begin @(negedge clk); n++; end
    chk("reach_23", int'(tens) * 10 + int'(ones), 23);
    start_stop_n = 1'b0; clear_n = 1'b0;
    @(negedge clk);
    clear_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("clr_running", int'(running), 0);
    chk("clr_ones", int'(ones), 0);
    chk("clr_tens", int'(tens), 0);
    repeat (8) @(negedge clk);
    chk("held_start_no_toggle", int'(running), 0);
    start_stop_n = 1'b1;
    repeat (3) @(negedge clk);
    press_btn(1'b0, 12);
    chk("held_start_runs", int'(running), 1);
    repeat (3) @(negedge clk);
    chk("held_start_once", int'(running), 1);

    // Asynchronous reset mid-count at 37.
    n = 0;
    while (!(tens == 4'd3 && ones == 4'd7) && n < 400) begin @(negedge clk); n++; end
    chk("reach_37", int'(tens) * 10 + int'(ones), 37);
    #2;
    reset_n = 1'b0;
    #1;
    chk("async_rst_ones", int'(ones), 0);
    chk("async_rst_tens", int'(tens), 0);
    chk("async_rst_running", int'(running), 0);
    chk("async_rst_wrap", int'(wrap), 0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (20) @(negedge clk);
    chk("post_rst_running", int'(running), 0);
    chk("post_rst_ones", int'(ones), 0);

    // Randomized button activity checked against the model every cycle.
    for (int i = 0; i < 800; i++) begin
      r = int'($urandom_range(0, 99));
      if (r < 5)       press_btn(1'b0, int'($urandom_range(1, 4)));
      else if (r < 7)  press_btn(1'b1, int'($urandom_range(1, 3)));
      else if (r < 8) begin
        start_stop_n = 1'b0; clear_n = 1'b0;
        @(negedge clk);
        start_stop_n = 1'b1; clear_n = 1'b1;
      end else @(negedge clk);
    end
    repeat (5) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_seconds_counter_60
`default_nettype wire

// File: doc/seconds_counter_60.md
# seconds_counter_60

Upstream stage of the 60-second timer. It divides the board clock down to a one-second tick and runs a BCD seconds counter from 00 to 59 under start/stop and clear pushbutton control. Its two 4-bit digit outputs feed directly into the two 7-segment decoders, one for ones and one for tens. Digit values never exceed 9 for ones or 5 for tens, so the decoders' A–F codes are never exercised.

## Interface
- `TICKS_PER_SEC`, default 50_000_000. Clock cycles per counted second. Minimum 2.
- `clk`, input, 1 bit. Board clock; all state updates on its rising edge.
- `reset_n`, input, 1 bit. Asynchronous, active-low reset.
- `start_stop_n`, input, 1 bit. Raw pushbutton, active-low and asynchronous to `clk`. Each press toggles run/pause.
- `clear_n`, input, 1 bit. Raw pushbutton, active-low and asynchronous. A press zeroes the count and stops.
- `ones`, output, 4 bits. BCD seconds ones digit, 0–9. Drives the ones decoder `X`.
- `tens`, output, 4 bits. BCD seconds tens digit, 0–5. Drives the tens decoder `X`.
- `running`, output, 1 bit. High while in RUN.
- `wrap`, output, 1 bit. One-cycle pulse on the 59→00 transition.

## Operation
- **Clock and reset.** One clock. Reset is asynchronous and active-low on `reset_n`.
- **Reset state.**
  - `ones` = 0, `tens` = 0, `running` = 0, `wrap` = 0.
  - Prescaler = 0, state = IDLE.
  - All synchronizer flops reset to 1 (button released).
- **Button conditioning.**
  - Each button passes through a 2-flop synchronizer, then a registered previous-value flop.
  - A press event is a 1→0 transition on the synchronized signal.
  - A held button yields exactly one event. No debounce; boards using this block supply clean buttons.
- **States.**
  - IDLE: count 00, prescaler held at 0.
  - RUN: prescaler counts.
  - PAUSE: prescaler and digits frozen at their current values.
- **Transitions.**
  - IDLE –start→ RUN.
  - RUN –start→ PAUSE.
  - PAUSE –start→ RUN.
  - Any state –clear→ IDLE. Clear zeroes the digits and the prescaler.
- **Simultaneous events.** If clear and start events occur in the same cycle, clear wins and the result is IDLE.
- **Prescaler.**
  - In RUN, it counts 0 … `TICKS_PER_SEC`−1 and wraps to 0.
  - The tick is the cycle in which the prescaler equals `TICKS_PER_SEC`−1.
  - Pause holds the prescaler value, so resuming completes the partial second.
- **BCD count, on a tick.**
  - If `ones` < 9: `ones` + 1.
  - Else: `ones` ← 0, and `tens` ← `tens` + 1, or `tens` ← 0 if `tens` = 5.
  - On 59→00, `wrap` = 1 for that one cycle. Counting continues in RUN after a wrap; there is no auto-stop.
- **Width.** Prescaler width is `$clog2(TICKS_PER_SEC)`. It never exceeds `TICKS_PER_SEC`−1.

## Timing
- **Button latency.** A press first sampled low at edge k produces its state change on the registers at edge k+2. `running` reflects it after edge k+2.
- **First increment.** From an IDLE→RUN transition at edge s, the first digit increment lands on edge s+`TICKS_PER_SEC`. Later increments follow every `TICKS_PER_SEC` cycles of RUN.
- **Digits and `wrap`.** The digit update and the `wrap` assertion happen on the same edge. `wrap` deasserts on the next edge.
- **All outputs are registered.** The decoders see stable digits for the whole cycle.
- **Reset mid-count.** Asserting `reset_n` low forces all outputs to their reset values immediately, with no clock needed. After release, the block sits in IDLE.
- **Clear with a tick.** Clear arriving in the same cycle as a tick wins: the result is 00 and `wrap` = 0.

## Structure
- **Package `timer_pkg`.**
  - State enum: IDLE, RUN, PAUSE.
  - BCD constants `ONES_MAX` = 9 and `TENS_MAX` = 5.
- **Sub-module `button_sync_edge`.** Instantiated twice, once per button.
  - Contains the 2-flop synchronizer and the falling-edge detector.
  - Output: one-cycle `press` pulse. Resets to "released".
- **Top level.** Holds the FSM, the prescaler and the BCD counter.

## Test plan
All scenarios use `TICKS_PER_SEC` = 4.
1. **Reset.** Hold `reset_n` low mid-count at 37 → outputs go 0/0/0/0 asynchronously; the block stays IDLE after release with no ticks.
2. **Start and count.** One start press, then 40 clocks → `running` = 1; digits read 00 → 01 after 4 cycles of RUN; reach 10 after 40 RUN cycles, with the 09→10 carry.
3. **Wrap.** Run 240 cycles → `tens:ones` reaches 5:9, then 0:0; `wrap` is high for exactly one cycle on that edge; counting continues at 01.
4. **Pause and resume.** Press start 2 cycles into a second → digits and prescaler freeze. Press again → the next increment occurs 2 RUN cycles later.
5. **Clear priority.** Assert clear and start presses in the same cycle at count 23 → IDLE, 00, `running` = 0. A held start button produces only one toggle.
